// File: rtl/vx_ibuffer_mq_pkg.sv
// Shared types and width helpers for the multi-queue instruction buffer.
package vx_ibuffer_pkg;

  typedef enum logic [0:0] {
    ARB_RR   = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_e;

  function automatic int unsigned calc_nw_w(input int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vx_ibuffer_mq_if.sv
// Decode-side, issue-side, flush and occupancy signals of the instruction buffer.
interface vx_ibuffer_mq_if
  import vx_ibuffer_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATAW     = 64
) ();
  localparam int unsigned NW_W  = calc_nw_w(NUM_WARPS);
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH);

  logic                       in_valid;
  logic [NW_W-1:0]            in_wid;
  logic [DATAW-1:0]           in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [NW_W-1:0]            out_wid;
  logic [DATAW-1:0]           out_data;
  logic                       out_ready;
  logic                       flush_valid;
  logic [NW_W-1:0]            flush_wid;
  logic [NUM_WARPS*CNT_W-1:0] count;

  modport master (
    output in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    input  in_ready, out_valid, out_wid, out_data, count
  );

  modport slave (
    input  in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    output in_ready, out_valid, out_wid, out_data, count
  );

endinterface

// File: rtl/vx_ibuffer_mq_queue.sv
// Per-warp circular FIFO. Entries leave storage at load; count drops only at pop,
// so it includes an entry parked in the output register.
module vx_ibuf_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATAW = 64,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic             flush,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] stored_q, stored_d, count_q, count_d;
  logic             enq, deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == int'(DEPTH) - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (stored_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  // An empty queue forwards the incoming push straight to the output register.
  assign head_data = empty ? data_in : mem[rd_q];
  assign enq       = push && !(load && empty);
  assign deq       = load && !empty;

  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    stored_d = stored_q;
    count_d  = count_q;
    if (flush) begin
      rd_d     = '0;
      wr_d     = '0;
      stored_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_d = ptr_inc(wr_q);
      if (deq) rd_d = ptr_inc(rd_q);
      stored_d = stored_q + CNT_W'(enq) - CNT_W'(deq);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      stored_q <= '0;
      count_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      stored_q <= stored_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_q] <= data_in;
  end

endmodule

// File: rtl/vx_ibuffer_mq.sv
// Multi-queue instruction buffer: one FIFO per warp, round-robin or fixed-priority
// selection onto a registered issue port, with per-warp flush and occupancy.
module vx_ibuffer_mq
  import vx_ibuffer_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATAW     = 64,
  parameter arb_mode_e   ARB_MODE  = ARB_RR
) (
  input logic              clk,
  input logic              reset,
  vx_ibuffer_mq_if.slave   bus
);
  localparam int unsigned NW_W  = calc_nw_w(NUM_WARPS);
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH);

  logic                 push, pop, can_load, any_req, found;
  logic [NUM_WARPS-1:0] q_push, q_pop, q_load, q_flush, q_empty, q_full, req;
  logic [CNT_W-1:0]     q_count [NUM_WARPS];
  logic [DATAW-1:0]     q_head  [NUM_WARPS];
  logic [NW_W-1:0]      winner, rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [NW_W-1:0]      out_wid_q, out_wid_d;
  logic [DATAW-1:0]     out_data_q, out_data_d;
  int                   idx;

  assign bus.in_ready  = !q_full[bus.in_wid] && !(bus.flush_valid && bus.flush_wid == bus.in_wid);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = out_valid_q && bus.out_ready;
  assign can_load      = !out_valid_q || pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_wid   = out_wid_q;
  assign bus.out_data  = out_data_q;

  // A warp being flushed never requests, so a coincident pop hands over to another warp.
  always_comb begin
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      q_push[w]  = push && (bus.in_wid == NW_W'(w));
      q_pop[w]   = pop && (out_wid_q == NW_W'(w));
      q_flush[w] = bus.flush_valid && (bus.flush_wid == NW_W'(w));
      req[w]     = (!q_empty[w] || q_push[w]) && !q_flush[w];
    end
  end

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int k = 0; k < int'(NUM_WARPS); k++) begin
      if (ARB_MODE == ARB_PRIO) idx = k;
      else                      idx = (int'(rr_ptr_q) + k) % int'(NUM_WARPS);
      if (req[idx] && !found) begin
        winner = NW_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < int'(NUM_WARPS); w++) begin
      q_load[w] = can_load && any_req && (winner == NW_W'(w));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_wid_d   = out_wid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (can_load) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_wid_d  = winner;
        out_data_d = q_head[winner];
        rr_ptr_d   = (int'(winner) == int'(NUM_WARPS) - 1) ? '0 : winner + 1'b1;
      end
    end else if (q_flush[out_wid_q]) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
    vx_ibuf_queue #(
      .DEPTH (DEPTH),
      .DATAW (DATAW),
      .CNT_W (CNT_W)
    ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push[w]),
      .pop       (q_pop[w]),
      .load      (q_load[w]),
      .flush     (q_flush[w]),
      .data_in   (bus.in_data),
      .head_data (q_head[w]),
      .count     (q_count[w]),
      .empty     (q_empty[w]),
      .full      (q_full[w])
    );
    assign bus.count[w*CNT_W +: CNT_W] = q_count[w];
  end

endmodule

// File: tb/tb_vx_ibuffer_mq.sv
// Bench for vx_ibuffer_mq: a round-robin and a priority instance share one stimulus
// stream; a queue-based model predicts both, plus literal spot checks.
module tb_vx_ibuffer_mq;
  import vx_ibuffer_pkg::*;

  localparam int unsigned NW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DATAW = 64;
  localparam int unsigned NW_W  = calc_nw_w(NW);
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [NW_W-1:0]  in_wid = '0;
  logic [DATAW-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             flush_valid = 1'b0;
  logic [NW_W-1:0]  flush_wid = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vx_ibuffer_mq_if #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW)) bus_rr ();
  vx_ibuffer_mq_if #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW)) bus_pr ();

  assign bus_rr.in_valid    = in_valid;
  assign bus_rr.in_wid      = in_wid;
  assign bus_rr.in_data     = in_data;
  assign bus_rr.out_ready   = out_ready;
  assign bus_rr.flush_valid = flush_valid;
  assign bus_rr.flush_wid   = flush_wid;
  assign bus_pr.in_valid    = in_valid;
  assign bus_pr.in_wid      = in_wid;
  assign bus_pr.in_data     = in_data;
  assign bus_pr.out_ready   = out_ready;
  assign bus_pr.flush_valid = flush_valid;
  assign bus_pr.flush_wid   = flush_wid;

  vx_ibuffer_mq #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW), .ARB_MODE(ARB_RR)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr)
  );

  vx_ibuffer_mq #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW), .ARB_MODE(ARB_PRIO)) dut_pr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_pr)
  );

  // Model: per-warp queues of not-yet-issued entries (index mode*NW+wid) plus the output slot.
  logic [DATAW-1:0] m_fifo [2*NW][$];
  logic             m_ov  [2];
  logic [NW_W-1:0]  m_ow  [2];
  logic [DATAW-1:0] m_od  [2];
  int               m_ptr [2];
  int               iss_wid [2][$];
  logic [DATAW-1:0] iss_data [2][$];

  function automatic int m_cnt(input int m, input int w);
    return m_fifo[m*NW+w].size() + ((m_ov[m] && int'(m_ow[m]) == w) ? 1 : 0);
  endfunction

  function automatic bit m_ready(input int m);
    return (m_cnt(m, int'(in_wid)) < int'(DEPTH)) && !(flush_valid && flush_wid == in_wid);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2*int'(NW); i++) m_fifo[i].delete();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 1'b0;
      m_ow[m] = '0;
      m_od[m] = '0;
      m_ptr[m] = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input int m, output logic ov, output logic [NW_W-1:0] ow,
                        output logic [DATAW-1:0] od, output logic rdy,
                        output logic [NW*CNT_W-1:0] cnt);
    if (m == 0) begin
      ov = bus_rr.out_valid; ow = bus_rr.out_wid; od = bus_rr.out_data;
      rdy = bus_rr.in_ready; cnt = bus_rr.count;
    end else begin
      ov = bus_pr.out_valid; ow = bus_pr.out_wid; od = bus_pr.out_data;
      rdy = bus_pr.in_ready; cnt = bus_pr.count;
    end
  endtask

  task automatic compare();
    logic ov, rdy;
    logic [NW_W-1:0] ow;
    logic [DATAW-1:0] od;
    logic [NW*CNT_W-1:0] cnt;
    for (int m = 0; m < 2; m++) begin
      sample(m, ov, ow, od, rdy, cnt);
      check($sformatf("m%0d out_valid", m), 64'(ov), 64'(m_ov[m]));
      if (m_ov[m]) begin
        check($sformatf("m%0d out_wid", m), 64'(ow), 64'(m_ow[m]));
        check($sformatf("m%0d out_data", m), 64'(od), 64'(m_od[m]));
      end
      check($sformatf("m%0d in_ready", m), 64'(rdy), 64'(m_ready(m)));
      for (int w = 0; w < int'(NW); w++)
        check($sformatf("m%0d count[%0d]", m, w), 64'(cnt[w*CNT_W +: CNT_W]), 64'(m_cnt(m, w)));
      if (ov && out_ready) begin
        iss_wid[m].push_back(int'(ow));
        iss_data[m].push_back(od);
      end
    end
  endtask

  task automatic advance();
    bit push, pop, may_load;
    int win, w;
    for (int m = 0; m < 2; m++) begin
      push = in_valid && m_ready(m);
      pop = m_ov[m] && out_ready;
      may_load = !m_ov[m] || pop;
      if (flush_valid) m_fifo[m*NW+int'(flush_wid)].delete();
      if (flush_valid && m_ov[m] && m_ow[m] == flush_wid && !pop) m_ov[m] = 1'b0;
      if (push) m_fifo[m*NW+int'(in_wid)].push_back(in_data);
      if (may_load) begin
        win = -1;
        for (int k = 0; k < int'(NW); k++) begin
          w = (m == 0) ? (m_ptr[m] + k) % int'(NW) : k;
          if (win < 0 && m_fifo[m*NW+w].size() > 0) win = w;
        end
        if (win >= 0) begin
          m_od[m] = m_fifo[m*NW+win].pop_front();
          m_ow[m] = NW_W'(win);
          m_ov[m] = 1'b1;
          m_ptr[m] = (win + 1) % int'(NW);
        end else begin
          m_ov[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int w, input logic [DATAW-1:0] d);
    in_valid = 1'b1;
    in_wid = NW_W'(w);
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_issued();
    for (int m = 0; m < 2; m++) begin
      iss_wid[m].delete();
      iss_data[m].delete();
    end
  endtask

  task automatic check_order(input int m, input string name, input int exp[8], input int n);
    check({name, " issue count"}, 64'(iss_wid[m].size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < iss_wid[m].size())
        check($sformatf("%s issue[%0d]", name, i), 64'(iss_wid[m][i]), 64'(exp[i]));
  endtask

  initial begin
    int ord_rr[8];
    int ord_pr[8];
    int ord_f[8];
    int n_w1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst out_valid", 64'(bus_rr.out_valid), 64'd0);
    check("rst in_ready", 64'(bus_rr.in_ready), 64'd1);
    check("rst count", 64'(bus_pr.count), 64'd0);
    tick();

    // Bypass into idle warp 2
    push_one(2, 64'hA5);
    check("bypass out_valid", 64'(bus_rr.out_valid), 64'd1);
    check("bypass out_wid", 64'(bus_rr.out_wid), 64'd2);
    check("bypass out_data", bus_rr.out_data, 64'hA5);
    check("bypass count2", 64'(bus_rr.count[2*CNT_W +: CNT_W]), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bypass pop valid", 64'(bus_rr.out_valid), 64'd0);
    check("bypass pop count2", 64'(bus_rr.count[2*CNT_W +: CNT_W]), 64'd0);

    // Fill warp 0 with backpressure, fifth push must be refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_wid = '0;
      in_data = 64'(100 + i);
      #1;
      if (i == 4) check("full in_ready", 64'(bus_rr.in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("full count0", 64'(bus_rr.count[0 +: CNT_W]), 64'd4);
    clear_issued();
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    check("drain count", 64'(iss_data[0].size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < iss_data[0].size()) check($sformatf("drain[%0d]", i), iss_data[0][i], 64'(100 + i));

    // Arbitration: two entries per warp, issued with out_ready held high
    for (int r = 0; r < 2; r++)
      for (int w = 0; w < int'(NW); w++) push_one(w, 64'(16 * w + r));
    clear_issued();
    out_ready = 1'b1;
    repeat (9) tick();
    out_ready = 1'b0;
    ord_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord_pr = '{0, 0, 1, 1, 2, 2, 3, 3};
    check_order(0, "rr", ord_rr, 8);
    check_order(1, "prio", ord_pr, 8);

    // Flush the warp whose head sits in the output register
    for (int i = 0; i < 3; i++) push_one(1, 64'(64'h100 + i));
    push_one(3, 64'h300);
    push_one(3, 64'h301);
    flush_valid = 1'b1;
    flush_wid = NW_W'(1);
    tick();
    flush_valid = 1'b0;
    check("flush out_valid", 64'(bus_rr.out_valid), 64'd0);
    check("flush count1", 64'(bus_pr.count[1*CNT_W +: CNT_W]), 64'd0);
    clear_issued();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    ord_f = '{3, 3, 0, 0, 0, 0, 0, 0};
    check_order(0, "flush rr", ord_f, 2);
    check_order(1, "flush prio", ord_f, 2);

    // Flush coincident with pop of the same warp and a push to it
    push_one(1, 64'h110);
    push_one(1, 64'h111);
    push_one(2, 64'h210);
    clear_issued();
    out_ready = 1'b1;
    flush_valid = 1'b1;
    flush_wid = NW_W'(1);
    in_valid = 1'b1;
    in_wid = NW_W'(1);
    in_data = 64'h1FF;
    #1;
    check("coinc in_ready", 64'(bus_rr.in_ready), 64'd0);
    tick();
    flush_valid = 1'b0;
    in_valid = 1'b0;
    check("coinc count1", 64'(bus_rr.count[1*CNT_W +: CNT_W]), 64'd0);
    repeat (3) tick();
    out_ready = 1'b0;
    n_w1 = 0;
    foreach (iss_wid[0][i]) if (iss_wid[0][i] == 1) n_w1++;
    check("coinc w1 issues", 64'(n_w1), 64'd1);
    ord_f = '{1, 2, 0, 0, 0, 0, 0, 0};
    check_order(0, "coinc rr", ord_f, 2);

    // Asynchronous reset between edges with six entries buffered
    for (int w = 0; w < 3; w++) begin
      push_one(w, 64'(w));
      push_one(w, 64'(w + 8));
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset out_valid", 64'(bus_rr.out_valid), 64'd0);
    check("areset count rr", 64'(bus_rr.count), 64'd0);
    check("areset count pr", 64'(bus_pr.count), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    push_one(3, 64'h77);
    check("post-reset out_valid", 64'(bus_pr.out_valid), 64'd1);
    check("post-reset out_wid", 64'(bus_pr.out_wid), 64'd3);
    check("post-reset out_data", bus_pr.out_data, 64'h77);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
